// File: rtl/cen_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// sequencer state encoding, standard-rate increments and width helpers.
package cen_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOAD   = 2'd2,
        ST_RUN    = 2'd3
    } cg_state_e;

    // Increments for a 93.068170 MHz system clock with a 32-bit accumulator
    localparam int unsigned STD_ACC_W  = 32;
    localparam logic [31:0] INC_14M318 = 32'd660764199;
    localparam logic [31:0] INC_7M159  = 32'd330382100;

    // Width needed to index n items, never narrower than one bit
    function automatic int unsigned cg_clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cen_accum_ch.sv
// Single phase-accumulator channel: active increment, accumulator and the
// registered enable pulse plus its divide-by-two pseudo-clock.
module cen_accum_ch
    import cen_gen_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic             pause,
    input  logic             clr,
    input  logic [ACC_W-1:0] shadow_inc,
    input  logic [ACC_W-1:0] shadow_phase,
    output logic             cen,
    output logic             tog
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             cen_q, cen_d;
    logic             tog_q, tog_d;
    logic [ACC_W:0]   sum_c;

    // Carry out of the modulo add is the enable; residue stays in acc
    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        cen_d = 1'b0;
        tog_d = tog_q;
        sum_c = {1'b0, acc_q} + {1'b0, inc_q};
        if (load) begin
            inc_d = shadow_inc;
            acc_d = shadow_phase;
        end else if (run && !pause) begin
            acc_d = sum_c[ACC_W-1:0];
            cen_d = sum_c[ACC_W];
            tog_d = tog_q ^ sum_c[ACC_W];
        end
        if (clr) begin
            tog_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            inc_q <= '0;
            cen_q <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            cen_q <= cen_d;
            tog_q <= tog_d;
        end
    end

    assign cen = cen_q;
    assign tog = tog_q;

endmodule

// File: rtl/cen_gen_multi.sv
// Multi-channel clock-enable generator: lock sequencer, shadow config file
// and NUM_CH phase-accumulator channels started coherently from one clock.
module cen_gen_multi
    import cen_gen_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 5,
    parameter  int unsigned ACC_W      = 32,
    parameter  int unsigned LOCK_DELAY = 1024,
    localparam int unsigned CH_W       = cg_clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              resync,
    input  logic [NUM_CH-1:0] pause,
    output logic [NUM_CH-1:0] cen,
    output logic [NUM_CH-1:0] tog,
    output logic              ready
);

    localparam int unsigned CNT_W = cg_clog2_min1(LOCK_DELAY);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic [ACC_W-1:0] sh_inc_q   [NUM_CH];
    logic [ACC_W-1:0] sh_inc_d   [NUM_CH];
    logic [ACC_W-1:0] sh_phase_q [NUM_CH];
    logic [ACC_W-1:0] sh_phase_d [NUM_CH];

    logic             hold_v_q, hold_v_d;
    logic [CH_W-1:0]  hold_ch_q, hold_ch_d;
    logic [ACC_W-1:0] hold_inc_q, hold_inc_d;
    logic [ACC_W-1:0] hold_phase_q, hold_phase_d;

    logic             load_c;
    logic             run_c;
    logic             clr_c;
    logic             resync_acc_c;
    logic             cfg_hit_c;
    logic [ACC_W-1:0] old_inc_c;
    logic [ACC_W-1:0] old_phase_c;

    // Lock sequencer: IDLE -> SETTLE (LOCK_DELAY cycles) -> LOAD -> RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pll_locked) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!pll_locked) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_DELAY - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!pll_locked) begin
                    state_d = ST_IDLE;
                end else if (resync) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Lock loss in RUN wins over accumulation so the exit cycle is already quiet
    always_comb begin
        load_c       = (state_q == ST_LOAD);
        run_c        = (state_q == ST_RUN) && pll_locked;
        clr_c        = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        resync_acc_c = (state_q == ST_RUN) && pll_locked && resync;
        cfg_hit_c    = cfg_we && (32'(cfg_ch) < NUM_CH);
    end

    // Shadow register file plus the value a write is about to replace
    always_comb begin
        old_inc_c   = '0;
        old_phase_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sh_inc_d[i]   = sh_inc_q[i];
            sh_phase_d[i] = sh_phase_q[i];
            if (cfg_ch == CH_W'(i)) begin
                old_inc_c   = sh_inc_q[i];
                old_phase_c = sh_phase_q[i];
                if (cfg_hit_c) begin
                    sh_inc_d[i]   = cfg_inc;
                    sh_phase_d[i] = cfg_phase;
                end
            end
        end
    end

    // A write landing with an accepted resync must not reach the LOAD it triggers
    always_comb begin
        hold_v_d     = resync_acc_c && cfg_hit_c;
        hold_ch_d    = cfg_ch;
        hold_inc_d   = old_inc_c;
        hold_phase_d = old_phase_c;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            hold_v_q     <= 1'b0;
            hold_ch_q    <= '0;
            hold_inc_q   <= '0;
            hold_phase_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sh_inc_q[i]   <= '0;
                sh_phase_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            hold_v_q     <= hold_v_d;
            hold_ch_q    <= hold_ch_d;
            hold_inc_q   <= hold_inc_d;
            hold_phase_q <= hold_phase_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sh_inc_q[i]   <= sh_inc_d[i];
                sh_phase_q[i] <= sh_phase_d[i];
            end
        end
    end

    assign ready = ready_q;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic             use_hold_c;
        logic [ACC_W-1:0] ld_inc_c;
        logic [ACC_W-1:0] ld_phase_c;

        assign use_hold_c = hold_v_q && (hold_ch_q == CH_W'(g));
        assign ld_inc_c   = use_hold_c ? hold_inc_q   : sh_inc_q[g];
        assign ld_phase_c = use_hold_c ? hold_phase_q : sh_phase_q[g];

        cen_accum_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .load         (load_c),
            .run          (run_c),
            .pause        (pause[g]),
            .clr          (clr_c),
            .shadow_inc   (ld_inc_c),
            .shadow_phase (ld_phase_c),
            .cen          (cen[g]),
            .tog          (tog[g])
        );
    end

endmodule

// File: tb/tb_cen_gen_multi.sv
// Directed bench for cen_gen_multi at ACC_W=8, LOCK_DELAY=4, NUM_CH=5 with
// hand-computed pulse positions (bit i of a history word = tick i of a window).
module tb_cen_gen_multi;

    localparam int unsigned NUM_CH     = 5;
    localparam int unsigned ACC_W      = 8;
    localparam int unsigned LOCK_DELAY = 4;
    localparam int unsigned CH_W       = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pll_locked;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              resync;
    logic [NUM_CH-1:0] pause;
    logic [NUM_CH-1:0] cen;
    logic [NUM_CH-1:0] tog;
    logic              ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cen_gen_multi #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .LOCK_DELAY (LOCK_DELAY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .resync     (resync),
        .pause      (pause),
        .cen        (cen),
        .tog        (tog),
        .ready      (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc,
                             input logic [ACC_W-1:0] ph);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Ticks until ready rises (bounded); also flags any enable seen meanwhile
    task automatic wait_ready(output int n, output logic cen_seen);
        n        = 0;
        cen_seen = 1'b0;
        do begin
            tick();
            n++;
            if (cen != '0) cen_seen = 1'b1;
        end while (!ready && n < 20);
    endtask

    task automatic record(input int len, output logic [31:0] h0, output logic [31:0] h1,
                          output logic [31:0] t0, output logic [NUM_CH-1:0] any_c);
        h0    = '0;
        h1    = '0;
        t0    = '0;
        any_c = '0;
        for (int i = 0; i < len; i++) begin
            tick();
            h0[i] = cen[0];
            h1[i] = cen[1];
            t0[i] = tog[0];
            any_c = any_c | cen;
        end
    endtask

    initial begin
        int                lat;
        logic              seen;
        logic [31:0]       h0, h1, t0;
        logic [NUM_CH-1:0] any_c;
        int                cnt0, cnt1, cnt2, bad_gap, last0;
        logic [NUM_CH-1:0] quiet;

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        cfg_phase  = '0;
        resync     = 1'b0;
        pause      = '0;

        repeat (3) tick();
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_cen",   32'(cen),   32'd0);
        chk("reset_tog",   32'(tog),   32'd0);
        reset_n = 1'b1;

        cfg_write(3'd0, 8'd64, 8'd0);
        cfg_write(3'd1, 8'd64, 8'd192);

        // Lock at T0 -> ready at T6, no enables before RUN
        pll_locked = 1'b1;
        wait_ready(lat, seen);
        chk("lock_latency", 32'(lat), 32'd6);
        chk("lock_cen_quiet", 32'(seen), 32'd0);

        // inc=64: ch0 phase 0 at ticks 4,8,..; ch1 phase 192 at ticks 1,5,..
        record(20, h0, h1, t0, any_c);
        chk("rate_cen0", h0, 32'h0008_8888);
        chk("rate_cen1", h1, 32'h0001_1111);
        chk("rate_tog0", t0, 32'h0008_7878);
        chk("inc0_silent", 32'(any_c[4:2]), 32'd0);

        // Shadow write during RUN must not disturb ch0 (ticks 22..36)
        cfg_write(3'd0, 8'd128, 8'd0);
        record(15, h0, h1, t0, any_c);
        chk("iso_cen0", h0, 32'h0000_4444);
        chk("iso_cen1", h1, 32'h0000_0888);

        // Resync with a same-cycle write to ch1 that must not take effect
        resync    = 1'b1;
        cfg_we    = 1'b1;
        cfg_ch    = 3'd1;
        cfg_inc   = 8'd32;
        cfg_phase = 8'd0;
        tick();
        resync = 1'b0;
        cfg_we = 1'b0;
        chk("load_not_ready", 32'(ready), 32'd0);
        record(16, h0, h1, t0, any_c);
        chk("resync_cen0", h0, 32'h0000_5554);
        chk("resync_cen1", h1, 32'h0000_2222);

        // Pause ch0 for 10 cycles, then resume from the held residue
        pause = 5'b00001;
        record(10, h0, h1, t0, any_c);
        chk("pause_cen0", h0, 32'h0);
        chk("pause_cen1", h1, 32'h0000_0222);
        chk("pause_tog0", t0, 32'h0);
        pause = '0;
        record(6, h0, h1, t0, any_c);
        chk("resume_cen0", h0, 32'h0000_0015);
        chk("resume_tog0", t0, 32'h0000_0033);

        // Lock loss mid-RUN: everything quiet on the next cycle
        pll_locked = 1'b0;
        tick();
        chk("loss_cen",   32'(cen),   32'd0);
        chk("loss_tog",   32'(tog),   32'd0);
        chk("loss_ready", 32'(ready), 32'd0);

        cfg_write(3'd0, 8'd85,  8'd0);
        cfg_write(3'd2, 8'd255, 8'd0);
        cfg_write(3'd7, 8'd99,  8'd99);

        // Lock drops at T2 during SETTLE; relock must take the full 6 cycles
        pll_locked = 1'b1;
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        chk("drop_not_ready", 32'(ready), 32'd0);
        pll_locked = 1'b1;
        wait_ready(lat, seen);
        chk("relock_latency", 32'(lat), 32'd6);

        // ch0 inc=85 over 255 cycles, ch1 inc=32 (earlier shadow), ch2 inc=255
        cnt0    = 0;
        cnt1    = 0;
        cnt2    = 0;
        bad_gap = 0;
        last0   = -1;
        quiet   = '0;
        for (int t = 1; t <= 256; t++) begin
            tick();
            if (t <= 255 && cen[0]) begin
                cnt0++;
                if (last0 >= 0 && (t - last0) != 3 && (t - last0) != 4) bad_gap++;
                last0 = t;
            end
            if (cen[1]) cnt1++;
            if (cen[2]) cnt2++;
            quiet = quiet | cen;
        end
        chk("frac_count", 32'(cnt0), 32'd84);
        chk("frac_gap",   32'(bad_gap), 32'd0);
        chk("shadow_ch1_count", 32'(cnt1), 32'd32);
        chk("inc255_count", 32'(cnt2), 32'd255);
        chk("ch3_ch4_silent", 32'(quiet[4:3]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
